fir_fp_coeff_bank: RTL and testbench

Upstream coefficient stage for the 4-tap single-precision floating-point FIR filter. It accepts a burst of four IEEE-754 coefficient words over a valid/ready stream into shadow registers and screens out non-finite values. It then commits all four atomically to the active outputs b0..b3, aligned to a sample strobe, so the filter never computes with a mix of old and new taps.

---
 rtl/fir_fp_coeff_bank.sv | 154 +++++++++++++++
 tb/tb_fir_fp_coeff_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_fp_coeff_bank.sv
// Coefficient bank for the 4-tap single-precision FIR.
// A burst of four IEEE-754 words is collected into shadow registers,
// screened for Inf/NaN, and then copied to b0..b3 in one cycle so the
// filter never sees a mix of old and new taps.
//
// state  | meaning
// IDLE   | no burst open, waiting for Load_Start
// LOAD   | accepting coefficient words into the shadow registers
// PEND   | clean burst held, waiting for Sample_Strobe
// COMMIT | copy shadow to active taps this cycle
module fir_fp_coeff_bank #(
  parameter int NTAPS        = 4,
  parameter bit STROBE_ALIGN = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Load_Start,
  input  logic        Load_Valid,
  input  logic [31:0] Load_Data,
  output logic        Load_Ready,
  input  logic        Sample_Strobe,
  output logic [31:0] b0,
  output logic [31:0] b1,
  output logic [31:0] b2,
  output logic [31:0] b3,
  output logic        Coef_Valid,
  output logic        Busy,
  output logic        Err
);

  localparam int CNT_W = $clog2(NTAPS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    PEND   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    bad_q, bad_d;
  logic                    err_q, err_d;
  logic                    cv_q, cv_d;
  logic [NTAPS-1:0][31:0]  shadow_q, shadow_d;
  logic [NTAPS-1:0][31:0]  act_q, act_d;

  logic word_bad;
  logic last_word;

  // Exponent all-ones marks Inf or NaN; sign and denormals pass through.
  assign word_bad  = &Load_Data[30:23];
  assign last_word = (cnt_q == CNT_W'(NTAPS - 1));

  // Next-state, burst framing and commit logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bad_d    = bad_q;
    err_d    = 1'b0;
    cv_d     = cv_q;
    shadow_d = shadow_q;
    act_d    = act_q;

    case (state_q)
      IDLE: begin
        if (Load_Start) begin
          state_d = LOAD;
          cnt_d   = '0;
          bad_d   = 1'b0;
        end
      end

      LOAD: begin
        // A fresh Load_Start always reframes, even on the 4th word.
        if (Load_Start) begin
          cnt_d = '0;
          bad_d = 1'b0;
        end else if (Load_Valid) begin
          shadow_d[cnt_q] = Load_Data;
          bad_d           = bad_q | word_bad;
          cnt_d           = cnt_q + CNT_W'(1);
          if (last_word) begin
            cnt_d = '0;
            if (bad_q | word_bad) begin
              err_d   = 1'b1;
              bad_d   = 1'b0;
              state_d = IDLE;
            end else if (STROBE_ALIGN) begin
              state_d = PEND;
            end else begin
              state_d = COMMIT;
            end
          end
        end
      end

      PEND: begin
        if (Load_Start) begin
          state_d = LOAD;
          cnt_d   = '0;
          bad_d   = 1'b0;
        end else if (Sample_Strobe) begin
          state_d = COMMIT;
        end
      end

      COMMIT: begin
        // The commit always completes; a coincident start opens the next burst.
        act_d   = shadow_q;
        cv_d    = 1'b1;
        state_d = IDLE;
        if (Load_Start) begin
          state_d = LOAD;
          cnt_d   = '0;
          bad_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, shadow and active tap registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bad_q    <= 1'b0;
      err_q    <= 1'b0;
      cv_q     <= 1'b0;
      shadow_q <= '0;
      act_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bad_q    <= bad_d;
      err_q    <= err_d;
      cv_q     <= cv_d;
      shadow_q <= shadow_d;
      act_q    <= act_d;
    end
  end

  assign Load_Ready = (state_q == LOAD);
  assign Busy       = (state_q == LOAD) | (state_q == PEND);
  assign Err        = err_q;
  assign Coef_Valid = cv_q;
  assign b0         = act_q[0];
  assign b1         = act_q[1];
  assign b2         = act_q[2];
  assign b3         = act_q[3];

endmodule

// File: tb/tb_fir_fp_coeff_bank.sv
// Bench for fir_fp_coeff_bank: one strobe-aligned and one immediate-commit
// instance share stimulus; each is compared every cycle against a
// burst-level reference model, plus a few fixed-value checks.
module tb_fir_fp_coeff_bank;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Load_Start, Load_Valid, Sample_Strobe;
  logic [31:0] Load_Data;

  logic        rdy1, cv1, busy1, err1;
  logic [31:0] b0_1, b1_1, b2_1, b3_1;
  logic        rdy0, cv0, busy0, err0;
  logic [31:0] b0_0, b1_0, b2_0, b3_0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  fir_fp_coeff_bank #(.NTAPS(4), .STROBE_ALIGN(1'b1)) dut1 (
    .Clk(Clk), .Rst(Rst), .Load_Start(Load_Start), .Load_Valid(Load_Valid),
    .Load_Data(Load_Data), .Load_Ready(rdy1), .Sample_Strobe(Sample_Strobe),
    .b0(b0_1), .b1(b1_1), .b2(b2_1), .b3(b3_1),
    .Coef_Valid(cv1), .Busy(busy1), .Err(err1));

  fir_fp_coeff_bank #(.NTAPS(4), .STROBE_ALIGN(1'b0)) dut0 (
    .Clk(Clk), .Rst(Rst), .Load_Start(Load_Start), .Load_Valid(Load_Valid),
    .Load_Data(Load_Data), .Load_Ready(rdy0), .Sample_Strobe(Sample_Strobe),
    .b0(b0_0), .b1(b1_0), .b2(b2_0), .b3(b3_0),
    .Coef_Valid(cv0), .Busy(busy0), .Err(err0));

  // Burst-level reference: words collected so far, whether a clean burst
  // is waiting for a strobe or due to land, and the visible taps.
  typedef struct packed {
    logic             loading;
    logic             waiting;
    logic             landing;
    logic [2:0]       n;
    logic             bad;
    logic             err;
    logic             cv;
    logic [3:0][31:0] w;
    logic [3:0][31:0] act;
  } mdl_t;

  mdl_t m1, m0;

  function automatic mdl_t mdl_step(mdl_t m, bit align, bit rst, bit start,
                                    bit valid, logic [31:0] data, bit strobe);
    mdl_t r = m;
    if (rst) return '0;
    r.err = 1'b0;
    if (m.landing) begin
      r.act     = m.w;
      r.cv      = 1'b1;
      r.landing = 1'b0;
    end
    if (start) begin
      r.loading = 1'b1;
      r.waiting = 1'b0;
      r.n       = 3'd0;
      r.bad     = 1'b0;
    end else if (m.loading && valid) begin
      r.w[m.n[1:0]] = data;
      r.bad = m.bad || (data[30:23] == 8'hFF);
      r.n   = m.n + 3'd1;
      if (r.n == 3'd4) begin
        r.loading = 1'b0;
        if (r.bad) r.err = 1'b1;
        else if (align) r.waiting = 1'b1;
        else r.landing = 1'b1;
      end
    end else if (m.waiting && strobe) begin
      r.waiting = 1'b0;
      r.landing = 1'b1;
    end
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_val("s1_b0", b0_1, m1.act[0]);
    check_val("s1_b1", b1_1, m1.act[1]);
    check_val("s1_b2", b2_1, m1.act[2]);
    check_val("s1_b3", b3_1, m1.act[3]);
    check_val("s1_cv", 32'(cv1), 32'(m1.cv));
    check_val("s1_busy", 32'(busy1), 32'(m1.loading | m1.waiting));
    check_val("s1_rdy", 32'(rdy1), 32'(m1.loading));
    check_val("s1_err", 32'(err1), 32'(m1.err));
    check_val("i0_b0", b0_0, m0.act[0]);
    check_val("i0_b1", b1_0, m0.act[1]);
    check_val("i0_b2", b2_0, m0.act[2]);
    check_val("i0_b3", b3_0, m0.act[3]);
    check_val("i0_cv", 32'(cv0), 32'(m0.cv));
    check_val("i0_busy", 32'(busy0), 32'(m0.loading | m0.waiting));
    check_val("i0_rdy", 32'(rdy0), 32'(m0.loading));
    check_val("i0_err", 32'(err0), 32'(m0.err));
  endtask

  // Inputs are set while Clk is low; the model steps on the rising edge
  // and outputs are compared on the following falling edge.
  task automatic cycle();
    @(posedge Clk);
    m1 = mdl_step(m1, 1'b1, Rst, Load_Start, Load_Valid, Load_Data, Sample_Strobe);
    m0 = mdl_step(m0, 1'b0, Rst, Load_Start, Load_Valid, Load_Data, Sample_Strobe);
    @(negedge Clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    Load_Start    = 1'b0;
    Load_Valid    = 1'b0;
    Load_Data     = 32'h0;
    Sample_Strobe = 1'b0;
  endtask

  task automatic start_pulse();
    Load_Start = 1'b1;
    cycle();
    Load_Start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    Load_Valid = 1'b1;
    Load_Data  = d;
    cycle();
    Load_Valid = 1'b0;
  endtask

  task automatic strobe_pulse();
    Sample_Strobe = 1'b1;
    cycle();
    Sample_Strobe = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    idle_inputs();
    Rst = 1'b1;
    m1 = '0;
    m0 = '0;
    #1;
    check_val("rst_b0_async", b0_1, 32'h0);
    check_val("rst_rdy", 32'(rdy1), 32'h0);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    repeat (3) cycle();
    check_val("idle_cv", 32'(cv1), 32'h0);
    check_val("idle_busy", 32'(busy1), 32'h0);

    // Clean burst, strobe five cycles later.
    start_pulse();
    send_word(32'h3F800000);
    send_word(32'h40000000);
    send_word(32'h40400000);
    send_word(32'h40800000);
    repeat (5) cycle();
    check_val("pend_busy", 32'(busy1), 32'h1);
    strobe_pulse();
    check_val("commit_not_yet", b0_1, 32'h0);
    cycle();
    check_val("commit_b0", b0_1, 32'h3F800000);
    check_val("commit_b3", b3_1, 32'h40800000);
    check_val("commit_cv", 32'(cv1), 32'h1);
    cycle();

    // NaN in the third word rejects the whole burst.
    start_pulse();
    send_word(32'h40A00000);
    send_word(32'h40C00000);
    send_word(32'h7FC00000);
    send_word(32'h40E00000);
    check_val("nan_err", 32'(err1), 32'h1);
    cycle();
    check_val("nan_err_clr", 32'(err1), 32'h0);
    check_val("nan_keep_b2", b2_1, 32'h40400000);
    strobe_pulse();
    cycle();

    // Gapped words, restart after two, then a full -0.5 burst.
    start_pulse();
    for (int i = 0; i < 2; i++) begin
      send_word(32'h41000000 + 32'(i));
      cycle();
      cycle();
    end
    start_pulse();
    for (int i = 0; i < 4; i++) send_word(32'hBF000000);
    cycle();
    strobe_pulse();
    cycle();
    check_val("restart_b1", b1_1, 32'hBF000000);
    check_val("restart_b3", b3_1, 32'hBF000000);

    // Immediate-commit instance lands 0.25 without any strobe.
    start_pulse();
    for (int i = 0; i < 4; i++) send_word(32'h3E800000);
    cycle();
    check_val("imm_b0", b0_0, 32'h3E800000);
    check_val("imm_b3", b3_0, 32'h3E800000);

    // Reset while the aligned instance is pending.
    check_val("pend_before_rst", 32'(busy1), 32'h1);
    #2;
    Rst = 1'b1;
    #1;
    check_val("rst_pend_b0", b0_1, 32'h0);
    check_val("rst_pend_cv", 32'(cv1), 32'h0);
    m1 = '0;
    m0 = '0;
    @(negedge Clk);
    Rst = 1'b0;
    strobe_pulse();
    cycle();
    check_val("rst_no_commit", b0_1, 32'h0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      Load_Start    = ($urandom_range(0, 24) == 0);
      Load_Valid    = ($urandom_range(0, 1) == 1);
      d             = $urandom;
      if ($urandom_range(0, 7) == 0) d[30:23] = 8'hFF;
      Load_Data     = d;
      Sample_Strobe = ($urandom_range(0, 9) == 0);
      Rst           = ($urandom_range(0, 599) == 0);
      cycle();
    end
    idle_inputs();
    Rst = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
